// File: rtl/s2p_pkg.sv
// Shared types and helpers for the serial-to-parallel gatherer.
package s2p_pkg;

  typedef enum logic {
    FILL = 1'b0,
    HELD = 1'b1
  } state_e;

  // Width needed to hold a lane count in the range 0..max_lanes.
  function automatic int unsigned cnt_width(input int unsigned max_lanes);
    return $clog2(max_lanes + 1);
  endfunction

  // Out-of-range group sizes (zero or larger than the lane count) select all lanes.
  function automatic int unsigned clamp_group(input int unsigned size, input int unsigned max_size);
    if ((size == 0) || (size > max_size)) begin
      return max_size;
    end
    return size;
  endfunction

endpackage

// File: rtl/s2p_out_slot.sv
// Single-entry valid/ready output register carrying a gathered word and its lane count.
module s2p_out_slot #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned CNT_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic [CNT_W-1:0]  load_count,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  out_count
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  count_q, count_d;

  // The producer only loads when the slot is empty or draining this cycle.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    count_d = count_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
      count_d = load_count;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_count = count_q;

endmodule

// File: rtl/s2p_gather.sv
// Gathers 1..MAX_LANES serial samples into one wide word with valid/ready backpressure and flush.
module s2p_gather
  import s2p_pkg::*;
#(
  parameter int unsigned MAX_LANES = 4,
  parameter int unsigned SAMPLE_W  = 32,
  parameter int unsigned CNT_W     = cnt_width(MAX_LANES)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [SAMPLE_W-1:0]           in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [CNT_W-1:0]              group_size,
  input  logic                          flush,
  output logic [MAX_LANES*SAMPLE_W-1:0] out_data,
  output logic [CNT_W-1:0]              out_count,
  output logic                          out_valid,
  input  logic                          out_ready
);

  localparam int unsigned DATA_W = MAX_LANES * SAMPLE_W;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    gs_q, gs_d;
  logic [DATA_W-1:0]   asm_q, asm_d;
  logic                in_ready_q, in_ready_d;

  logic                accept_c;
  logic                out_free_c;
  logic                done_c;
  logic [CNT_W-1:0]    gs_eff_c;
  logic [CNT_W-1:0]    cnt_p_c;
  logic [DATA_W-1:0]   written_c;

  logic                load;
  logic [DATA_W-1:0]   load_data;
  logic [CNT_W-1:0]    load_count;

  assign out_free_c = !out_valid || out_ready;

  // Next-state, assembly update and output-slot load decision.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gs_d       = gs_q;
    asm_d      = asm_q;
    load       = 1'b0;
    load_data  = asm_q;
    load_count = cnt_q;
    accept_c   = 1'b0;
    done_c     = 1'b0;
    gs_eff_c   = gs_q;
    cnt_p_c    = cnt_q;
    written_c  = asm_q;

    unique case (state_q)
      FILL: begin
        accept_c = in_valid && in_ready_q;
        // A new group starts from an all-zero word so unwritten lanes read as zero.
        written_c = (cnt_q == '0) ? '0 : asm_q;
        if (accept_c) begin
          for (int unsigned i = 0; i < MAX_LANES; i++) begin
            if (CNT_W'(i) == cnt_q) begin
              written_c[i*SAMPLE_W +: SAMPLE_W] = in_data;
            end
          end
        end
        if (accept_c && (cnt_q == '0)) begin
          gs_eff_c = CNT_W'(clamp_group(32'(group_size), MAX_LANES));
        end
        cnt_p_c = cnt_q + CNT_W'(accept_c);
        done_c  = (accept_c && (cnt_p_c == gs_eff_c)) || (flush && (cnt_p_c != '0));

        if (accept_c) begin
          gs_d  = gs_eff_c;
          asm_d = written_c;
          cnt_d = cnt_p_c;
        end
        if (done_c) begin
          if (out_free_c) begin
            load       = 1'b1;
            load_data  = written_c;
            load_count = cnt_p_c;
            cnt_d      = '0;
            asm_d      = '0;
          end else begin
            // cnt_q keeps the lane count of the parked group while HELD.
            state_d = HELD;
          end
        end
      end

      HELD: begin
        if (out_ready) begin
          load       = 1'b1;
          load_data  = asm_q;
          load_count = cnt_q;
          cnt_d      = '0;
          asm_d      = '0;
          state_d    = FILL;
        end
      end

      default: begin
        state_d = FILL;
      end
    endcase

    in_ready_d = (state_d == FILL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= FILL;
      cnt_q      <= '0;
      gs_q       <= '0;
      asm_q      <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gs_q       <= gs_d;
      asm_q      <= asm_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready = in_ready_q;

  s2p_out_slot #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_out_slot (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .load_data  (load_data),
    .load_count (load_count),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_count  (out_count)
  );

endmodule

// File: tb/tb_s2p_gather.sv
// Self-checking bench for s2p_gather: queue-based reference model plus directed literal checks.
module tb_s2p_gather;

  localparam int unsigned ML = 4;
  localparam int unsigned SW = 32;
  localparam int unsigned CW = 3;
  localparam int unsigned DW = ML * SW;

  logic          clk = 1'b0;
  logic          rst;
  logic [SW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] group_size;
  logic          flush;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_count;
  logic          out_valid;
  logic          out_ready;

  always #5 clk = ~clk;

  s2p_gather #(
    .MAX_LANES (ML),
    .SAMPLE_W  (SW),
    .CNT_W     (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .group_size (group_size),
    .flush      (flush),
    .out_data   (out_data),
    .out_count  (out_count),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: partial group as a queue, one output slot, one parked word.
  logic [SW-1:0] m_part[$];
  int            m_gs;
  bit            m_slot_v;
  logic [DW-1:0] m_slot_d;
  int            m_slot_c;
  bit            m_held_v;
  logic [DW-1:0] m_held_d;
  int            m_held_c;

  function automatic int clamp_size(input int g);
    return ((g == 0) || (g > int'(ML))) ? int'(ML) : g;
  endfunction

  function automatic logic [DW-1:0] pack_part();
    logic [DW-1:0] w;
    w = '0;
    for (int i = 0; i < m_part.size(); i++) w[i*SW +: SW] = m_part[i];
    return w;
  endfunction

  task automatic model_reset();
    m_part.delete();
    m_gs     = 0;
    m_slot_v = 1'b0;
    m_slot_d = '0;
    m_slot_c = 0;
    m_held_v = 1'b0;
    m_held_d = '0;
    m_held_c = 0;
  endtask

  task automatic model_step();
    bit acc, free, complete;
    acc  = in_valid && !m_held_v;
    free = !m_slot_v || out_ready;
    if (m_held_v) begin
      if (out_ready) begin
        m_slot_d = m_held_d;
        m_slot_c = m_held_c;
        m_held_v = 1'b0;
      end
    end else begin
      if (acc) begin
        if (m_part.size() == 0) m_gs = clamp_size(int'(group_size));
        m_part.push_back(in_data);
      end
      complete = (acc && (m_part.size() == m_gs)) || (flush && (m_part.size() > 0));
      if (complete) begin
        if (free) begin
          m_slot_v = 1'b1;
          m_slot_d = pack_part();
          m_slot_c = m_part.size();
        end else begin
          m_held_v = 1'b1;
          m_held_d = pack_part();
          m_held_c = m_part.size();
        end
        m_part.delete();
      end else if (m_slot_v && out_ready) begin
        m_slot_v = 1'b0;
      end
    end
  endtask

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic compare_model();
    check("in_ready", DW'(in_ready), DW'(!m_held_v));
    check("out_valid", DW'(out_valid), DW'(m_slot_v));
    if (m_slot_v) begin
      check("out_data", out_data, m_slot_d);
      check("out_count", DW'(out_count), DW'(m_slot_c));
    end
  endtask

  // One clock: update the model with the inputs present at the edge, then compare.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_model();
  endtask

  task automatic send(input logic [SW-1:0] d, input bit f);
    in_valid = 1'b1;
    in_data  = d;
    flush    = f;
    tick();
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    flush    = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk_reset_vals(input string tag);
    check({tag, "_out_valid"}, DW'(out_valid), '0);
    check({tag, "_out_data"}, out_data, '0);
    check({tag, "_out_count"}, DW'(out_count), '0);
    check({tag, "_in_ready"}, DW'(in_ready), DW'(1'b1));
  endtask

  initial begin
    rst        = 1'b1;
    in_data    = '0;
    in_valid   = 1'b0;
    group_size = '0;
    flush      = 1'b0;
    out_ready  = 1'b1;
    model_reset();
    #1;
    chk_reset_vals("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Basic gather of three samples, then the next sample lands in lane 0.
    group_size = 3'd3;
    send(32'h11, 1'b0);
    send(32'h22, 1'b0);
    send(32'h33, 1'b0);
    check("basic_valid", DW'(out_valid), DW'(1'b1));
    check("basic_data", out_data, {32'h0, 32'h33, 32'h22, 32'h11});
    check("basic_count", DW'(out_count), DW'(3'd3));
    send(32'h44, 1'b0);
    send(32'h55, 1'b0);
    send(32'h66, 1'b0);
    check("basic_next_data", out_data, {32'h0, 32'h66, 32'h55, 32'h44});
    idle(2);

    // Backpressure: one word in the slot, one parked, then release.
    group_size = 3'd2;
    out_ready  = 1'b0;
    for (int i = 0; i < 4; i++) send(SW'(32'h100 + i), 1'b0);
    check("bp_in_ready_low", DW'(in_ready), '0);
    check("bp_word1", out_data, {32'h0, 32'h0, 32'h101, 32'h100});
    in_valid  = 1'b1;
    in_data   = 32'h104;
    out_ready = 1'b1;
    tick();
    check("bp_word2", out_data, {32'h0, 32'h0, 32'h103, 32'h102});
    check("bp_in_ready_back", DW'(in_ready), DW'(1'b1));
    for (int i = 4; i < 8; i++) send(SW'(32'h100 + i), 1'b0);
    idle(2);

    // Flush together with a sample, then flush on an empty group.
    group_size = 3'd4;
    send(32'hA, 1'b0);
    send(32'hB, 1'b0);
    send(32'hC, 1'b1);
    check("flush_data", out_data, {32'h0, 32'hC, 32'hB, 32'hA});
    check("flush_count", DW'(out_count), DW'(3'd3));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_empty", DW'(out_valid), '0);
    idle(1);

    // Mode change mid-group takes effect at the next group.
    group_size = 3'd4;
    send(32'h21, 1'b0);
    send(32'h22, 1'b0);
    group_size = 3'd2;
    send(32'h23, 1'b0);
    check("mode_mid_valid", DW'(out_valid), '0);
    send(32'h24, 1'b0);
    check("mode_first_count", DW'(out_count), DW'(3'd4));
    send(32'h25, 1'b0);
    send(32'h26, 1'b0);
    check("mode_second_count", DW'(out_count), DW'(3'd2));
    check("mode_second_data", out_data, {32'h0, 32'h0, 32'h26, 32'h25});
    idle(1);

    // Clamp of out-of-range sizes to all lanes.
    group_size = 3'd0;
    for (int i = 0; i < 4; i++) send(SW'(32'h30 + i), 1'b0);
    check("clamp0_count", DW'(out_count), DW'(3'd4));
    group_size = 3'd7;
    for (int i = 0; i < 4; i++) send(SW'(32'h40 + i), 1'b0);
    check("clamp7_count", DW'(out_count), DW'(3'd4));
    send(32'h50, 1'b0);
    check("clamp_new_word", DW'(out_valid), '0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("clamp_flush_count", DW'(out_count), DW'(3'd1));
    idle(1);

    // Group size 1: one word per cycle with no bubbles.
    group_size = 3'd1;
    for (int i = 0; i < 5; i++) send(SW'(32'h60 + i), 1'b0);
    idle(1);

    // Asynchronous reset in the middle of a group.
    group_size = 3'd3;
    send(32'h91, 1'b0);
    send(32'h92, 1'b0);
    #3 rst = 1'b1;
    #1;
    chk_reset_vals("midrst");
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    send(32'h7, 1'b0);
    send(32'h8, 1'b0);
    send(32'h9, 1'b0);
    check("midrst_new_data", out_data, {32'h0, 32'h9, 32'h8, 32'h7});
    check("midrst_new_count", DW'(out_count), DW'(3'd3));
    idle(2);

    // Randomized traffic checked against the model every cycle.
    for (int c = 0; c < 3000; c++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      in_data    = $urandom;
      group_size = CW'($urandom_range(0, 7));
      flush      = ($urandom_range(0, 7) == 0);
      out_ready  = ($urandom_range(0, 9) < 7);
      tick();
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
